fetch_queue: RTL and testbench
==============================

# fetch_queue

Instruction prefetch queue between the instruction memory and the IF/ID pipeline register of the 5-stage RV64 core. It issues sequential word fetches, buffers up to DEPTH returned instructions with their PCs, and presents them in order to decode through a valid/ready handshake. Taken branches and jumps resolved in EX/MEM redirect it through a flush port. Decode backpressure (hazard stall) is absorbed by the queue, so the PC no longer has to freeze.

## Interface
- DEPTH, 4, queue entries; power of two, ≥2
- RESET_PC, 64'h0, fetch address after reset
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-low reset
- imem_req_valid  out  1  fetch request valid
- imem_req_addr  out  64  fetch address; bits [1:0] always 0
- imem_req_ready  in  1  memory accepts request this cycle
- imem_rsp_valid  in  1  response valid; in order, no backpressure, ≥1 cycle after acceptance
- imem_rsp_data  in  32  instruction word
- redirect_valid  in  1  flush and restart fetch
- redirect_pc  in  64  new fetch address; bits [1:0] ignored
- id_valid  out  1  head entry valid
- id_instr  out  32  head instruction
- id_pc  out  64  head PC
- id_ready  in  1  decode accepts head (low = stall)
- occupancy  out  $clog2(DEPTH)+1  entries held

## Operation
- State: fetch_pc, circular buffer of {pc, instr} with rd/wr pointers, count, outstanding counter (accepted requests without response), drop counter, response-PC FIFO of DEPTH entries.
- Request: imem_req_valid = rst & !redirect_valid & (count + outstanding < DEPTH). imem_req_addr = fetch_pc. On valid & ready: fetch_pc += 4 (wraps mod 2^64), outstanding += 1, fetch_pc pushed to response-PC FIFO.
- Response: outstanding -= 1, PC popped. If drop counter ≠ 0: data discarded, drop counter -= 1. Else {pc, data} enqueued.
- Dequeue: id_valid = (count ≠ 0) & !redirect_valid; head shown on id_instr/id_pc. id_valid & id_ready pops head.
- Simultaneous enqueue and dequeue: count unchanged, both pointers advance. Full: unreachable by credit rule (count + outstanding ≤ DEPTH always).
- Redirect (one cycle): queue emptied (count 0, pointers equal), fetch_pc ← {redirect_pc[63:2], 2'b00}, drop counter ← outstanding after this cycle's response decrement, response-PC FIFO cleared logically. Response arriving in redirect cycle is discarded. No request, no dequeue that cycle.
- Back-to-back redirects: last wins; drop counter recomputed each time.
- Reset (rst low): fetch_pc ← RESET_PC; count, outstanding, drop, pointers ← 0. Responses still in memory are not tracked; memory is reset with the same rst.

## Timing
- Reset values: imem_req_valid 0, imem_req_addr RESET_PC, id_valid 0, id_instr 0, id_pc 0, occupancy 0. id_instr/id_pc read 0 whenever count = 0 (without bypass).
- First request: cycle after rst deasserts.
- Response → id_valid: next cycle (registered enqueue), unless bypass enabled.
- Redirect → first request at redirect_pc: next cycle.
- Outputs id_valid and imem_req_valid combinational from state and redirect_valid only; no path from id_ready or imem_req_ready to them.
- Sustained throughput: one instruction/cycle with single-cycle memory and id_ready high.

## Configuration
- FETCH_QUEUE_BYPASS_EN defined: when count = 0, drop = 0, no redirect, and imem_rsp_valid high, response drives id_valid/id_instr/id_pc same cycle; if id_ready, entry not written; else enqueued normally. Adds combinational path imem_rsp_* → id_*.
- Undefined: every response is enqueued first; minimum response-to-decode latency one cycle; id_* purely registered-state outputs.

## Test plan
- Reset, 1-cycle memory, id_ready=1: requests at 0x0,0x4,0x8…; id_pc sequence 0x0,0x4,0x8 one per cycle; occupancy ≤1.
- id_ready=0 for 10 cycles: exactly DEPTH=4 requests issued, occupancy 4, imem_req_valid 0; release → PCs 0x0..0xC delivered in order, no loss or duplicate.
- Memory latency 3 cycles, 3 requests outstanding, redirect_pc=0x103: three stale responses discarded, next id_pc 0x100, instr equals memory word at 0x100.
- Redirect in same cycle as response and id_ready=1: response dropped, id_valid 0 that cycle, next request address = redirect target.
- fetch_pc at 0xFFFF_FFFF_FFFF_FFFC: next request address 0x0.
- Bypass: with FETCH_QUEUE_BYPASS_EN, empty queue, response in cycle N → id_valid in N, occupancy stays 0; without macro → id_valid in N+1, occupancy 1 in N+1.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: issues sequential fetches, buffers {pc, instr}, feeds decode in order.
// Define FETCH_QUEUE_BYPASS_EN to forward a response to decode in the same cycle when the queue is empty.

module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   imem_req_valid,
  output logic [63:0]            imem_req_addr,
  input  logic                   imem_req_ready,
  input  logic                   imem_rsp_valid,
  input  logic [31:0]            imem_rsp_data,
  input  logic                   redirect_valid,
  input  logic [63:0]            redirect_pc,
  output logic                   id_valid,
  output logic [31:0]            id_instr,
  output logic [63:0]            id_pc,
  input  logic                   id_ready,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] CREDITS = (CW+1)'(DEPTH);

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t        q_mem   [DEPTH];
  logic [63:0]   pc_fifo [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr, pf_rd, pf_wr;
  logic [CW-1:0] count, outstanding, drop, outstanding_dec;
  logic [CW:0]   inflight;
  logic [63:0]   fetch_pc, rsp_pc;
  entry_t        head;
  logic          q_empty, drop_zero, rsp_keep, req_fire, enq, deq;
  logic          unused_pc_bits;

  assign unused_pc_bits = ^redirect_pc[1:0];

  // Credit rule: queued + in-flight never exceeds DEPTH, so enqueue never finds the queue full.
  assign inflight       = {1'b0, count} + {1'b0, outstanding};
  assign imem_req_valid = rst & ~redirect_valid & (inflight < CREDITS);
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid & imem_req_ready;

  assign q_empty   = (count == '0);
  assign drop_zero = (drop == '0);
  assign rsp_keep  = imem_rsp_valid & drop_zero & ~redirect_valid;
  assign rsp_pc    = pc_fifo[pf_rd];
  assign head      = q_mem[rd_ptr];
  assign deq       = ~q_empty & ~redirect_valid & id_ready;
  assign occupancy = count;
  assign outstanding_dec = outstanding - CW'(imem_rsp_valid);

`ifdef FETCH_QUEUE_BYPASS_EN
  logic byp;
  assign byp      = rsp_keep & q_empty;
  assign id_valid = (~q_empty | byp) & ~redirect_valid;
  assign id_instr = ~q_empty ? head.instr : (byp ? imem_rsp_data : 32'h0);
  assign id_pc    = ~q_empty ? head.pc    : (byp ? rsp_pc        : 64'h0);
  assign enq      = rsp_keep & ~(byp & id_ready);
`else
  assign id_valid = ~q_empty & ~redirect_valid;
  assign id_instr = q_empty ? 32'h0 : head.instr;
  assign id_pc    = q_empty ? 64'h0 : head.pc;
  assign enq      = rsp_keep;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc    <= RESET_PC;
      count       <= '0;
      outstanding <= '0;
      drop        <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      pf_rd       <= '0;
      pf_wr       <= '0;
    end else if (redirect_valid) begin
      // Everything still in flight after this cycle belongs to the old stream.
      fetch_pc    <= {redirect_pc[63:2], 2'b00};
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      pf_rd       <= pf_wr;
      outstanding <= outstanding_dec;
      drop        <= outstanding_dec;
    end else begin
      if (req_fire) begin
        fetch_pc <= fetch_pc + 64'd4;
        pf_wr    <= pf_wr + 1'b1;
      end
      outstanding <= outstanding_dec + CW'(req_fire);
      if (imem_rsp_valid) begin
        if (!drop_zero) drop  <= drop - 1'b1;
        else            pf_rd <= pf_rd + 1'b1;
      end
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(enq) - CW'(deq);
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) pc_fifo[pf_wr] <= fetch_pc;
    if (enq)      q_mem[wr_ptr]  <= {rsp_pc, imem_rsp_data};
  end

  credit_bound: assert property (@(posedge clk) disable iff (!rst) inflight <= CREDITS);

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: vector table for streaming/stall, hand sequences for redirect and wrap.

module tb_fetch_queue;
  localparam int DEPTH = 4;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk, rst;
  logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic [63:0] imem_req_addr;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        id_valid, id_ready;
  logic [31:0] id_instr;
  logic [63:0] id_pc;
  logic [2:0]  occupancy;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(64'h0)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc), .id_ready(id_ready),
    .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [63:0] a);
    return a[31:0] ^ 32'h5EED_0013;
  endfunction

  // Fixed-latency memory: response lat_sel+1 cycles after acceptance.
  logic [3:0]  mp_v;
  logic [63:0] mp_a [4];
  logic [1:0]  lat_sel;
  int          req_cnt;

  always @(posedge clk) begin
    if (!rst) begin
      mp_v    <= '0;
      req_cnt <= 0;
    end else begin
      mp_v <= {mp_v[2:0], imem_req_valid & imem_req_ready};
      if (imem_req_valid & imem_req_ready) req_cnt <= req_cnt + 1;
    end
    mp_a[0] <= imem_req_addr;
    for (int i = 1; i < 4; i++) mp_a[i] <= mp_a[i-1];
  end

  assign imem_rsp_valid = mp_v[lat_sel];
  assign imem_rsp_data  = word(mp_a[lat_sel]);

  typedef struct {
    logic        rst_v;
    logic        rdy;
    logic        req_v;
    logic [63:0] addr;
    logic        idv;
    logic [63:0] pc;
    logic [2:0]  occ;
  } vec_t;

  vec_t tbl[$];
  int   n_chk, n_fail;

  function automatic vec_t mk(input logic r, input logic rdy, input logic rv, input logic [63:0] a,
                              input logic iv, input logic [63:0] p, input logic [2:0] o);
    vec_t v;
    v.rst_v = r; v.rdy = rdy; v.req_v = rv; v.addr = a; v.idv = iv; v.pc = p; v.occ = o;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic apply_reset(input logic [1:0] lat);
    rst = 1'b0; redirect_valid = 1'b0; id_ready = 1'b1; lat_sel = lat;
    repeat (2) @(negedge clk);
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      rst = tbl[i].rst_v; id_ready = tbl[i].rdy;
      #1;
      chk($sformatf("row%0d req_valid", i), imem_req_valid, tbl[i].req_v);
      chk($sformatf("row%0d req_addr", i), imem_req_addr, tbl[i].addr);
      chk($sformatf("row%0d id_valid", i), id_valid, tbl[i].idv);
      chk($sformatf("row%0d id_pc", i), id_pc, tbl[i].pc);
      chk($sformatf("row%0d id_instr", i), id_instr, tbl[i].idv ? word(tbl[i].pc) : 32'h0);
      chk($sformatf("row%0d occupancy", i), occupancy, tbl[i].occ);
      @(negedge clk);
    end
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (id_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    bit ok;
    rst = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b1;
    imem_req_ready = 1'b1; lat_sel = 2'd0; n_chk = 0; n_fail = 0;

    // Streaming, 1-cycle memory, decode always ready (rows 0-5).
    tbl.push_back(mk(0, 1, 0, 64'h0,  0,   64'h0, 0));
    tbl.push_back(mk(1, 1, 1, 64'h0,  0,   64'h0, 0));
    tbl.push_back(mk(1, 1, 1, 64'h4,  BYP, 64'h0, 0));
    tbl.push_back(mk(1, 1, 1, 64'h8,  1, BYP ? 64'h4 : 64'h0, BYP ? 3'd0 : 3'd1));
    tbl.push_back(mk(1, 1, 1, 64'hC,  1, BYP ? 64'h8 : 64'h4, BYP ? 3'd0 : 3'd1));
    tbl.push_back(mk(1, 1, 1, 64'h10, 1, BYP ? 64'hC : 64'h8, BYP ? 3'd0 : 3'd1));
    // Decode stalled ten cycles (rows 6-16), then released (rows 17-21).
    tbl.push_back(mk(0, 0, 0, 64'h0,  0,   64'h0, 0));
    tbl.push_back(mk(1, 0, 1, 64'h0,  0,   64'h0, 0));
    tbl.push_back(mk(1, 0, 1, 64'h4,  BYP, 64'h0, 0));
    tbl.push_back(mk(1, 0, 1, 64'h8,  1,   64'h0, 1));
    tbl.push_back(mk(1, 0, 1, 64'hC,  1,   64'h0, 2));
    tbl.push_back(mk(1, 0, 0, 64'h10, 1,   64'h0, 3));
    for (int i = 0; i < 5; i++) tbl.push_back(mk(1, 0, 0, 64'h10, 1, 64'h0, 4));
    tbl.push_back(mk(1, 1, 0, 64'h10, 1,   64'h0,  4));
    tbl.push_back(mk(1, 1, 1, 64'h10, 1,   64'h4,  3));
    tbl.push_back(mk(1, 1, 1, 64'h14, 1,   64'h8,  2));
    tbl.push_back(mk(1, 1, 1, 64'h18, 1,   64'hC,  2));
    tbl.push_back(mk(1, 1, 1, 64'h1C, 1,   64'h10, 2));

    apply_reset(2'd0);
    run_rows(0, 5);
    apply_reset(2'd0);
    run_rows(6, 16);
    chk("stall request count", 64'(req_cnt), 64'd4);
    run_rows(17, 21);

    // Three-cycle memory, redirect with three fetches in flight.
    apply_reset(2'd2);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 64'h103; #1;
    chk("A redirect req_valid", imem_req_valid, 1'b0);
    chk("A redirect id_valid", id_valid, 1'b0);
    @(negedge clk); redirect_valid = 1'b0; #1;
    chk("A target req_valid", imem_req_valid, 1'b1);
    chk("A target addr", imem_req_addr, 64'h100);
    wait_valid(ok);
    chk("A wait id_valid", ok, 1'b1);
    chk("A first id_pc", id_pc, 64'h100);
    chk("A first id_instr", id_instr, word(64'h100));
    @(negedge clk);

    // Redirect coinciding with a response while decode is ready.
    apply_reset(2'd0);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk); redirect_valid = 1'b1; redirect_pc = 64'h200; #1;
    chk("B redirect id_valid", id_valid, 1'b0);
    chk("B redirect req_valid", imem_req_valid, 1'b0);
    @(negedge clk); redirect_valid = 1'b0; #1;
    chk("B target req_valid", imem_req_valid, 1'b1);
    chk("B target addr", imem_req_addr, 64'h200);
    chk("B flushed occupancy", occupancy, 3'd0);
    chk("B flushed id_valid", id_valid, 1'b0);
    chk("B flushed id_pc", id_pc, 64'h0);
    @(negedge clk); #1;
    chk("B response-cycle id_valid", id_valid, BYP);
    @(negedge clk); #1;
    chk("B next id_valid", id_valid, 1'b1);
    chk("B next id_pc", id_pc, BYP ? 64'h204 : 64'h200);
    chk("B next occupancy", occupancy, BYP ? 3'd0 : 3'd1);
    @(negedge clk);

    // Fetch address wraps from the top of the address space.
    redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFF; #1;
    @(negedge clk); redirect_valid = 1'b0; #1;
    chk("C top req_valid", imem_req_valid, 1'b1);
    chk("C top addr", imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    @(negedge clk); #1;
    chk("C wrap req_valid", imem_req_valid, 1'b1);
    chk("C wrap addr", imem_req_addr, 64'h0);
    wait_valid(ok);
    chk("C wait id_valid", ok, 1'b1);
    chk("C top id_pc", id_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    @(negedge clk); #1;
    chk("C wrap id_valid", id_valid, 1'b1);
    chk("C wrap id_pc", id_pc, 64'h0);
    chk("C wrap id_instr", id_instr, word(64'h0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
